// File: rtl/hazard_control_unit.sv
// hazard_control_unit: decode-stage sequencing control. Resolves load-use,
// taken-branch and mult/div occupancy hazards, selects operand forwarding
// sources, and keeps saturating stall/flush event counters.
module hazard_control_unit #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_reg_write,
  input  logic [4:0]       i_ex_dest,
  input  logic             i_mem_reg_write,
  input  logic [4:0]       i_mem_dest,
  input  logic             i_branch_taken,
  input  logic             i_md_start,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_idex_hold,
  output logic             o_exmem_bubble,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_MD_BUSY = 1'b1;

  // Counter loads MULDIV_CYCLES-2 so that RUN is re-entered after
  // MULDIV_CYCLES-1 busy cycles; 5 bits covers the full 1..16 range.
  localparam int              DC_W    = 5;
  localparam logic [DC_W-1:0] DC_LOAD = (MULDIV_CYCLES > 1) ? DC_W'(MULDIV_CYCLES - 2) : '0;
  localparam logic            MD_MULTI = (MULDIV_CYCLES > 1);

  logic [0:0]       r_state;
  logic [DC_W-1:0]  r_dcnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_load_use;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Load-use: a load in EX targets a register the ID instruction reads.
  always_comb begin
    w_load_use = i_ex_mem_read && (i_ex_dest != 5'd0) &&
                 ((i_ex_dest == i_id_rs) || (i_id_uses_rt && (i_ex_dest == i_id_rt)));
  end

  // Forwarding select: EX result beats MEM result; r0 never forwards and
  // a load in EX has no result yet.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (i_ex_reg_write && !i_ex_mem_read && (i_ex_dest != 5'd0) && (i_ex_dest == i_id_rs))
      w_fwd_a = 2'b10;
    else if (i_mem_reg_write && (i_mem_dest != 5'd0) && (i_mem_dest == i_id_rs))
      w_fwd_a = 2'b01;
    if (i_id_uses_rt) begin
      if (i_ex_reg_write && !i_ex_mem_read && (i_ex_dest != 5'd0) && (i_ex_dest == i_id_rt))
        w_fwd_b = 2'b10;
      else if (i_mem_reg_write && (i_mem_dest != 5'd0) && (i_mem_dest == i_id_rt))
        w_fwd_b = 2'b01;
    end
  end

  // Pipeline control outputs, priority reset > busy > load-use > branch > normal.
  always_comb begin
    o_pc_write     = 1'b1;
    o_ifid_write   = 1'b1;
    o_ifid_flush   = 1'b0;
    o_idex_bubble  = 1'b0;
    o_idex_hold    = 1'b0;
    o_exmem_bubble = 1'b0;
    o_busy         = 1'b0;
    o_fwd_a        = w_fwd_a;
    o_fwd_b        = w_fwd_b;
    if (i_reset) begin
      o_pc_write     = 1'b0;
      o_ifid_write   = 1'b0;
      o_ifid_flush   = 1'b1;
      o_idex_bubble  = 1'b1;
      o_exmem_bubble = 1'b1;
      o_fwd_a        = 2'b00;
      o_fwd_b        = 2'b00;
    end else if (r_state == S_MD_BUSY) begin
      o_pc_write     = 1'b0;
      o_ifid_write   = 1'b0;
      o_idex_hold    = 1'b1;
      o_exmem_bubble = 1'b1;
      o_busy         = 1'b1;
    end else if (w_load_use) begin
      // A coincident branch is dropped; ID re-evaluates it next cycle.
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_idex_bubble = 1'b1;
    end else if (i_branch_taken) begin
      o_ifid_flush = 1'b1;
    end
  end

  // Mult/div occupancy FSM with down-counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_RUN;
      r_dcnt  <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_md_start && MD_MULTI) begin
            r_state <= S_MD_BUSY;
            r_dcnt  <= DC_LOAD;
          end
        end
        default: begin
          if (r_dcnt == '0) r_state <= S_RUN;
          else              r_dcnt  <= r_dcnt - DC_W'(1);
        end
      endcase
    end
  end

  // Saturating debug event counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!o_pc_write && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (o_ifid_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_stall_count = r_stall_cnt;
  assign o_flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_hazard_control_unit;
  localparam int MD    = 4;
  localparam int CW    = 4;
  localparam int SMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs = '0, rt = '0, ex_dest = '0, mem_dest = '0;
  logic uses_rt = 0, ex_mem_read = 0, ex_reg_write = 0, mem_reg_write = 0, br = 0, md_start = 0;

  logic pc_w, ifid_w, ifid_fl, idex_bub, idex_hold, exmem_bub, busy;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_control_unit #(.MULDIV_CYCLES(MD), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rt(uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_reg_write(ex_reg_write), .i_ex_dest(ex_dest),
    .i_mem_reg_write(mem_reg_write), .i_mem_dest(mem_dest),
    .i_branch_taken(br), .i_md_start(md_start),
    .o_pc_write(pc_w), .o_ifid_write(ifid_w), .o_ifid_flush(ifid_fl),
    .o_idex_bubble(idex_bub), .o_idex_hold(idex_hold), .o_exmem_bubble(exmem_bub),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_busy(busy),
    .o_stall_count(stall_cnt), .o_flush_count(flush_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int busy_left = 0;   // remaining busy cycles
  int m_stall = 0, m_flush = 0;
  logic e_pc, e_ifw, e_fl, e_bub, e_hold, e_exb, e_busy, lu;
  int e_fa, e_fb;

  function automatic int fw(input logic [4:0] op, input logic exw, input logic exr,
                            input logic [4:0] exd, input logic mw, input logic [4:0] md);
    if (exw && !exr && exd != 0 && exd == op) return 2;
    if (mw && md != 0 && md == op) return 1;
    return 0;
  endfunction

  always @* begin
    e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0; e_exb = 0; e_busy = 0;
    lu = ex_mem_read && ex_dest != 0 && (ex_dest == rs || (uses_rt && ex_dest == rt));
    e_fa = fw(rs, ex_reg_write, ex_mem_read, ex_dest, mem_reg_write, mem_dest);
    e_fb = uses_rt ? fw(rt, ex_reg_write, ex_mem_read, ex_dest, mem_reg_write, mem_dest) : 0;
    if (rst) begin
      e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1; e_exb = 1; e_fa = 0; e_fb = 0;
    end else if (busy_left > 0) begin
      e_pc = 0; e_ifw = 0; e_hold = 1; e_exb = 1; e_busy = 1;
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_bub = 1;
    end else if (br) begin
      e_fl = 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_stall < SMAX) m_stall = m_stall + 1;
      if (e_fl && m_flush < SMAX) m_flush = m_flush + 1;
      if (busy_left > 0) busy_left = busy_left - 1;
      else if (md_start && MD > 1) busy_left = MD - 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    chk("pc_write", int'(pc_w), int'(e_pc));
    chk("ifid_write", int'(ifid_w), int'(e_ifw));
    chk("ifid_flush", int'(ifid_fl), int'(e_fl));
    chk("idex_bubble", int'(idex_bub), int'(e_bub));
    chk("idex_hold", int'(idex_hold), int'(e_hold));
    chk("exmem_bubble", int'(exmem_bub), int'(e_exb));
    chk("busy", int'(busy), int'(e_busy));
    chk("fwd_a", int'(fwd_a), e_fa);
    chk("fwd_b", int'(fwd_b), e_fb);
    chk("stall_count", int'(stall_cnt), m_stall);
    chk("flush_count", int'(flush_cnt), m_flush);
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs = 0; rt = 0; uses_rt = 0; ex_mem_read = 0; ex_reg_write = 0; ex_dest = 0;
    mem_reg_write = 0; mem_dest = 0; br = 0; md_start = 0;
  endtask

  task automatic rand_in(input int reg_max, input int md_pct);
    rs = 5'($urandom_range(reg_max)); rt = 5'($urandom_range(reg_max));
    ex_dest = 5'($urandom_range(reg_max)); mem_dest = 5'($urandom_range(reg_max));
    uses_rt = 1'($urandom); ex_mem_read = 1'($urandom); ex_reg_write = 1'($urandom);
    mem_reg_write = 1'($urandom); br = 1'($urandom);
    md_start = ($urandom_range(99) < md_pct);
  endtask

  task automatic do_reset();
    next_cycle(); idle(); rst = 1;
    next_cycle(); rst = 0;
  endtask

  initial begin : main
    int nb;
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); rand_in(31, 50);
      #2;
      chk("rst_pc_write", int'(pc_w), 0);
      chk("rst_ifid_flush", int'(ifid_fl), 1);
      chk("rst_stall_count", int'(stall_cnt), 0);
    end
    next_cycle(); idle(); rst = 0;
    #2;
    chk("post_rst_pc_write", int'(pc_w), 1);
    chk("post_rst_fwd_a", int'(fwd_a), 0);

    // Load-use: one stall cycle.
    next_cycle(); ex_mem_read = 1; ex_dest = 5; rs = 5;
    #2;
    chk("lu_pc_write", int'(pc_w), 0);
    chk("lu_idex_bubble", int'(idex_bub), 1);
    next_cycle(); idle();
    #2;
    chk("lu_stall_count", int'(stall_cnt), 1);
    next_cycle(); ex_mem_read = 1; ex_dest = 0; rs = 0;
    #2;
    chk("lu_r0_pc_write", int'(pc_w), 1);

    // Forwarding.
    next_cycle(); idle();
    ex_reg_write = 1; ex_dest = 3; mem_reg_write = 1; mem_dest = 3; rs = 3; rt = 3; uses_rt = 1;
    #2;
    chk("fwd_ex_a", int'(fwd_a), 2);
    chk("fwd_ex_b", int'(fwd_b), 2);
    next_cycle(); ex_reg_write = 0;
    #2;
    chk("fwd_mem_a", int'(fwd_a), 1);
    chk("fwd_mem_b", int'(fwd_b), 1);
    next_cycle(); uses_rt = 0;
    #2;
    chk("fwd_nort_b", int'(fwd_b), 0);

    // Branch, then branch plus load-use.
    do_reset(); idle(); br = 1;
    #2;
    chk("br_flush", int'(ifid_fl), 1);
    next_cycle(); idle();
    #2;
    chk("br_flush_count", int'(flush_cnt), 1);
    next_cycle(); br = 1; ex_mem_read = 1; ex_dest = 7; rs = 7;
    #2;
    chk("br_lu_flush", int'(ifid_fl), 0);
    chk("br_lu_pc_write", int'(pc_w), 0);
    next_cycle(); idle();
    #2;
    chk("br_lu_flush_count", int'(flush_cnt), 1);

    // Mult/div occupancy.
    do_reset(); idle(); md_start = 1;
    #2;
    chk("md_start_busy", int'(busy), 0);
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      next_cycle(); md_start = 0;
      #2;
      if (busy) begin
        nb++;
        chk("md_hold", int'(idex_hold), 1);
      end
    end
    chk("md_busy_cycles", nb, MD - 1);
    chk("md_stall_count", int'(stall_cnt), MD - 1);
    next_cycle(); md_start = 1;
    next_cycle(); md_start = 0;
    next_cycle(); rst = 1;
    #2;
    chk("md_rst_busy", int'(busy), 0);
    next_cycle(); rst = 0;

    // Saturation.
    do_reset(); idle(); ex_mem_read = 1; ex_dest = 5; rs = 5;
    for (int i = 0; i < 20; i++) next_cycle();
    idle();
    #2;
    chk("sat_stall_count", int'(stall_cnt), SMAX);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      next_cycle();
      if (rst) rst = 0;
      else if ($urandom_range(59) == 0) rst = 1;
      rand_in(3, 12);
    end
    next_cycle(); idle(); rst = 0;
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
